iq_free_list_param: RTL
=======================

IQ_FREE_LIST_PARAM -- requirements
Module: iq_free_list_param

Interface
REQ-001 Parameter: IQ_DEPTH, default 32, number of issue-queue entries; SHALL be a power of 2 in the range 8..128.
REQ-002 Parameter: IQ_DEPTH_LOG, default 5, log2(IQ_DEPTH).
REQ-003 Parameter: DISP_W, default 4, maximum entries allocated per cycle (1..8).
REQ-004 Parameter: FREE_W, default 4, number of grant ports and number of reclaim banks; IQ_DEPTH SHALL be divisible by FREE_W.
REQ-005 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-006 alloc_valid_i  in  1  dispatch requests an allocation this cycle.
REQ-007 alloc_cnt_i  in  clog2(DISP_W+1)  number of entries requested (0..DISP_W).
REQ-008 alloc_ready_o  out  1  high when free_cnt_o >= alloc_cnt_i and ctrl_mispredict_i is low.
REQ-009 alloc_entry_o  out  DISP_W*IQ_DEPTH_LOG  slot k holds the free-list entry at head+k.
REQ-010 granted_valid_i  in  FREE_W  per-port issue-grant valid.
REQ-011 granted_entry_i  in  FREE_W*IQ_DEPTH_LOG  per-port granted entry index.
REQ-012 ctrl_mispredict_i  in  1  branch mispredict.
REQ-013 mispredict_vec_i  in  IQ_DEPTH  entries squashed by the mispredict.
REQ-014 freed_valid_o  out  FREE_W  per-bank reclaim valid this cycle.
REQ-015 freed_entry_o  out  FREE_W*IQ_DEPTH_LOG  per-bank reclaimed entry index.
REQ-016 free_cnt_o  out  IQ_DEPTH_LOG+1  number of free entries.
REQ-017 occ_cnt_o  out  IQ_DEPTH_LOG+1  occupied entries; always equals IQ_DEPTH - free_cnt_o.

Function
REQ-018 Free list: a circular FIFO of IQ_DEPTH entries with head and tail pointers of IQ_DEPTH_LOG bits that wrap modulo IQ_DEPTH.
REQ-019 Allocation fires only when alloc_valid_i and alloc_ready_o are both high; on fire, head advances by alloc_cnt_i at the next edge.
REQ-020 alloc_entry_o is combinational from head; slots at index >= alloc_cnt_i are don't-care.
REQ-021 Pending vector (IQ_DEPTH bits): a granted valid port sets its entry's bit at the next edge.
REQ-022 Banking: bank b covers entries [b*IQ_DEPTH/FREE_W, (b+1)*IQ_DEPTH/FREE_W-1]; each cycle each bank reclaims the lowest-index set pending bit, drives freed_valid_o[b] high with the absolute index, and clears that bit at the next edge.
REQ-023 If a grant and a reclaim hit the same bit in the same cycle, the grant wins and the bit stays set.
REQ-024 Reclaimed entries are written compacted at tail, tail+1, ..., in ascending bank order, skipping invalid banks; tail advances by popcount(freed_valid_o).
REQ-025 free_cnt next = free_cnt - (fired ? alloc_cnt_i : 0) + popcount(freed_valid_o), with pop and push in the same cycle.
REQ-026 Reclaim is combinational from the registered pending vector; there is one cycle of latency from grant to freed_valid_o.
REQ-027 While ctrl_mispredict_i is high, no allocation fires and head holds; reclaim continues.
REQ-028 A grant to an entry whose bit is already pending has no further effect; the bit is never double-counted.
REQ-029 free_cnt_o never exceeds IQ_DEPTH; alloc_ready_o is low when free_cnt_o is 0 and alloc_cnt_i > 0.

Reset
REQ-030 On reset, list[i] = i for all i, head = 0, tail = 0, the pending vector is 0, free_cnt_o = IQ_DEPTH, occ_cnt_o = 0, and freed_valid_o = 0.
REQ-031 Reset overrides any concurrent allocation, grant or mispredict in the same cycle.

Configuration
REQ-032 Macro IQFL_SQUASH_RECLAIM_EN: when defined, on ctrl_mispredict_i the pending vector next = (pending | mispredict_vec_i) with REQ-021 and REQ-023 applied; squashed entries then drain through the banks.
REQ-033 Without IQFL_SQUASH_RECLAIM_EN: mispredict_vec_i is ignored, and squashed entries SHALL be returned by the issue queue through the grant ports.

Verification
REQ-034 Reset, then alloc_cnt 4 for 8 cycles -> entries 0..31 delivered in order, free_cnt_o reaches 0, alloc_ready_o goes low.
REQ-035 Empty list; grant entries 3, 9, 17, 30 in one cycle -> next cycle freed_valid_o = 4'b1111 with entries 3, 9, 17, 30; free_cnt_o becomes 4 one cycle after that.
REQ-036 Grant entries 1 and 2 (same bank) -> reclaimed 1 and then 2 on consecutive cycles; a re-grant of 2 during the reclaim of 2 leaves it pending.
REQ-037 Head at 30, alloc_cnt 4 -> entries list[30], list[31], list[0], list[1]; head becomes 2 (wrap).
REQ-038 With IQFL_SQUASH_RECLAIM_EN: mispredict with vec 0x0000_00F0 while alloc_valid_i is high -> no allocation fires, then entries 4..7 are reclaimed one per cycle from bank 0.
REQ-039 Simultaneous alloc 2 and freed 3 with free_cnt 5 -> free_cnt_o becomes 6; occ_cnt_o + free_cnt_o = 32 on every cycle.

Source files
------------

// File: rtl/iq_free_list_param_if.sv
// Issue-queue free-list bus: dispatch allocation, issue grants, mispredict squash
// and per-bank reclaim status. The free list itself sits on the slave side.
interface iq_free_list_param_if #(
    parameter int IQ_DEPTH     = 32,
    parameter int IQ_DEPTH_LOG = 5,
    parameter int DISP_W       = 4,
    parameter int FREE_W       = 4
);
    localparam int CNT_W = $clog2(DISP_W + 1);

    logic                             alloc_valid_i;
    logic [CNT_W-1:0]                 alloc_cnt_i;
    logic                             alloc_ready_o;
    logic [DISP_W*IQ_DEPTH_LOG-1:0]   alloc_entry_o;
    logic [FREE_W-1:0]                granted_valid_i;
    logic [FREE_W*IQ_DEPTH_LOG-1:0]   granted_entry_i;
    logic                             ctrl_mispredict_i;
    logic [IQ_DEPTH-1:0]              mispredict_vec_i;
    logic [FREE_W-1:0]                freed_valid_o;
    logic [FREE_W*IQ_DEPTH_LOG-1:0]   freed_entry_o;
    logic [IQ_DEPTH_LOG:0]            free_cnt_o;
    logic [IQ_DEPTH_LOG:0]            occ_cnt_o;

    modport master (
        output alloc_valid_i, alloc_cnt_i, granted_valid_i, granted_entry_i,
               ctrl_mispredict_i, mispredict_vec_i,
        input  alloc_ready_o, alloc_entry_o, freed_valid_o, freed_entry_o,
               free_cnt_o, occ_cnt_o
    );

    modport slave (
        input  alloc_valid_i, alloc_cnt_i, granted_valid_i, granted_entry_i,
               ctrl_mispredict_i, mispredict_vec_i,
        output alloc_ready_o, alloc_entry_o, freed_valid_o, freed_entry_o,
               free_cnt_o, occ_cnt_o
    );
endinterface

// File: rtl/iq_free_list_param.sv
// Issue-queue free list: circular FIFO of entry indices with banked reclaim of granted entries.
// Optional macro IQFL_SQUASH_RECLAIM_EN folds the mispredict squash vector into the pending set.
module iq_free_list_param #(
    parameter int IQ_DEPTH     = 32,
    parameter int IQ_DEPTH_LOG = 5,
    parameter int DISP_W       = 4,
    parameter int FREE_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    iq_free_list_param_if.slave  bus
);
    localparam int LW      = IQ_DEPTH_LOG;
    localparam int FW      = IQ_DEPTH_LOG + 1;
    localparam int BANK_SZ = IQ_DEPTH / FREE_W;

    logic [LW-1:0]       r_list [IQ_DEPTH];
    logic [LW-1:0]       r_head;
    logic [LW-1:0]       r_tail;
    logic [IQ_DEPTH-1:0] r_pending;
    logic [FW-1:0]       r_free_cnt;

    logic                w_ready;
    logic                w_fire;
    logic [FREE_W-1:0]   w_freed_valid;
    logic [LW-1:0]       w_freed_idx [FREE_W];
    logic [LW-1:0]       w_push_off  [FREE_W];
    logic [FW-1:0]       w_push_cnt;
    logic [IQ_DEPTH-1:0] w_set;
    logic [IQ_DEPTH-1:0] w_clr;
    logic [IQ_DEPTH-1:0] w_squash;
    logic [IQ_DEPTH-1:0] w_pending_nxt;
    logic [FW-1:0]       w_dec;
    logic [FW:0]         w_free_sum;
    logic [FW-1:0]       w_free_nxt;

    assign w_ready = (r_free_cnt >= FW'(bus.alloc_cnt_i)) && !bus.ctrl_mispredict_i;
    assign w_fire  = bus.alloc_valid_i && w_ready;

    // Lowest set pending bit per bank; scanning downward leaves the lowest index last.
    always_comb begin
        w_freed_valid = '0;
        for (int b = 0; b < FREE_W; b++) begin
            w_freed_idx[b] = '0;
            for (int i = BANK_SZ - 1; i >= 0; i--) begin
                if (r_pending[b*BANK_SZ + i]) begin
                    w_freed_valid[b] = 1'b1;
                    w_freed_idx[b]   = LW'(b*BANK_SZ + i);
                end
            end
        end
    end

    always_comb begin
        w_push_cnt = '0;
        w_clr      = '0;
        for (int b = 0; b < FREE_W; b++) begin
            w_push_off[b] = LW'(w_push_cnt);
            if (w_freed_valid[b]) begin
                w_clr[w_freed_idx[b]] = 1'b1;
                w_push_cnt            = w_push_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        w_set = '0;
        for (int p = 0; p < FREE_W; p++) begin
            if (bus.granted_valid_i[p]) begin
                w_set[bus.granted_entry_i[p*LW +: LW]] = 1'b1;
            end
        end
    end

`ifdef IQFL_SQUASH_RECLAIM_EN
    assign w_squash = bus.ctrl_mispredict_i ? bus.mispredict_vec_i : '0;
`else
    // Squashed entries come back through the grant ports, so the vector is unused here.
    logic w_unused_mvec;
    assign w_unused_mvec = ^bus.mispredict_vec_i;
    assign w_squash      = '0;
`endif

    // Set after clear: a grant landing on a bit being reclaimed keeps it pending.
    assign w_pending_nxt = ((r_pending | w_squash) & ~w_clr) | w_set;

    assign w_dec      = w_fire ? FW'(bus.alloc_cnt_i) : '0;
    assign w_free_sum = {1'b0, r_free_cnt} - {1'b0, w_dec} + {1'b0, w_push_cnt};
    assign w_free_nxt = (w_free_sum > (FW+1)'(IQ_DEPTH)) ? FW'(IQ_DEPTH) : w_free_sum[FW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_list[i] <= LW'(i);
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_pending  <= '0;
            r_free_cnt <= FW'(IQ_DEPTH);
        end else begin
            for (int b = 0; b < FREE_W; b++) begin
                if (w_freed_valid[b]) begin
                    r_list[r_tail + w_push_off[b]] <= w_freed_idx[b];
                end
            end
            if (w_fire) begin
                r_head <= r_head + LW'(bus.alloc_cnt_i);
            end
            r_tail     <= r_tail + LW'(w_push_cnt);
            r_pending  <= w_pending_nxt;
            r_free_cnt <= w_free_nxt;
        end
    end

    for (genvar k = 0; k < DISP_W; k++) begin : g_alloc
        assign bus.alloc_entry_o[k*LW +: LW] = r_list[r_head + LW'(k)];
    end

    for (genvar b = 0; b < FREE_W; b++) begin : g_freed
        assign bus.freed_entry_o[b*LW +: LW] = w_freed_idx[b];
    end

    assign bus.alloc_ready_o = w_ready;
    assign bus.freed_valid_o = w_freed_valid;
    assign bus.free_cnt_o    = r_free_cnt;
    assign bus.occ_cnt_o     = FW'(IQ_DEPTH) - r_free_cnt;
endmodule
